// File: rtl/decode_regfile_scoreboard.sv
// decode_regfile_scoreboard: register file with write bypass and a pending-write scoreboard for decode hazard stalls
//   clk, reset (async active-low)
//   raddr/ruse -> rdata : RPORTS combinational read ports, bypassed from same-cycle writebacks
//   we/waddr/wdata      : WPORTS writeback ports, highest index wins on address collision
//   issue/issue_we/issue_dest : marks the destination pending when the instruction leaves decode
//   flush               : clears all pending bits
//   stall               : RAW on a used source or WAW on the destination
//   pending             : scoreboard, one bit per register
module decode_regfile_scoreboard #(
  parameter int RPORTS   = 2,
  parameter int WPORTS   = 1,
  parameter int ADDR     = 5,
  parameter int WIDTH    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [RPORTS-1:0][ADDR-1:0]    raddr,
  input  logic [RPORTS-1:0]              ruse,
  output logic [RPORTS-1:0][WIDTH-1:0]   rdata,
  input  logic [WPORTS-1:0]              we,
  input  logic [WPORTS-1:0][ADDR-1:0]    waddr,
  input  logic [WPORTS-1:0][WIDTH-1:0]   wdata,
  input  logic                           issue,
  input  logic                           issue_we,
  input  logic [ADDR-1:0]                issue_dest,
  input  logic                           flush,
  output logic                           stall,
  output logic [2**ADDR-1:0]             pending
);
  localparam int N = 2**ADDR;
  localparam bit ZR = ZERO_REG != 0;
  logic [N-1:0][WIDTH-1:0] regs;
  logic [N-1:0]            wb_hit;
  logic [N-1:0]            pend_nxt;
  always_comb begin
    wb_hit = '0;
    for (int w = 0; w < WPORTS; w++)
      if (we[w]) wb_hit[waddr[w]] = 1'b1;
  end
  // later ports override earlier ones so the highest-index write is forwarded
  always_comb begin
    rdata = '0;
    for (int p = 0; p < RPORTS; p++) begin
      rdata[p] = regs[raddr[p]];
      for (int w = 0; w < WPORTS; w++)
        if (we[w] && waddr[w] == raddr[p]) rdata[p] = wdata[w];
      if (!reset || (ZR && raddr[p] == '0)) rdata[p] = '0;
    end
  end
  // a same-cycle writeback to the register resolves the hazard, so it does not stall
  always_comb begin
    stall = issue_we && pending[issue_dest] && !wb_hit[issue_dest];
    for (int p = 0; p < RPORTS; p++)
      if (ruse[p] && pending[raddr[p]] && !wb_hit[raddr[p]]) stall = 1'b1;
  end
  // set after clear: the issuing instruction is the newest producer
  always_comb begin
    pend_nxt = pending & ~wb_hit;
    if (issue && issue_we && !stall && !(ZR && issue_dest == '0)) pend_nxt[issue_dest] = 1'b1;
    if (flush) pend_nxt = '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs    <= '0;
      pending <= '0;
    end else begin
      pending <= pend_nxt;
      for (int w = 0; w < WPORTS; w++)
        if (we[w] && !(ZR && waddr[w] == '0)) regs[waddr[w]] <= wdata[w];
    end
  end
endmodule

// File: tb/tb_decode_regfile_scoreboard.sv
// tb_decode_regfile_scoreboard: directed self-checking bench for decode_regfile_scoreboard
module tb_decode_regfile_scoreboard;
  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0][4:0]      raddr;
  logic [1:0]           ruse;
  logic [1:0][31:0]     rdata;
  logic [1:0]           we;
  logic [1:0][4:0]      waddr;
  logic [1:0][31:0]     wdata;
  logic                 issue, issue_we, flush, stall;
  logic [4:0]           issue_dest;
  logic [31:0]          pending;
  int n_chk = 0;
  int n_fail = 0;

  decode_regfile_scoreboard #(.RPORTS(2), .WPORTS(2), .ADDR(5), .WIDTH(32), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .raddr(raddr), .ruse(ruse), .rdata(rdata),
    .we(we), .waddr(waddr), .wdata(wdata), .issue(issue), .issue_we(issue_we),
    .issue_dest(issue_dest), .flush(flush), .stall(stall), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ruse = '0; we = '0; waddr = '0; wdata = '0;
    issue = 1'b0; issue_we = 1'b0; issue_dest = '0; flush = 1'b0;
  endtask

  task automatic drive();
    @(negedge clk);
    idle();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    raddr = '0;
    idle();
    // reset: writeback and bypass must not reach rdata
    @(negedge clk);
    we = 2'b01; waddr[0] = 5'd3; wdata[0] = 32'h55; raddr[0] = 5'd3;
    issue = 1'b1; issue_we = 1'b1; issue_dest = 5'd2;
    #1;
    chk("rst_rdata0", rdata[0], 32'h0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_pending", pending, 32'h0);
    tick();
    chk("rst_pending_edge", pending, 32'h0);
    drive();
    reset = 1'b1;
    raddr[0] = 5'd3;
    #1;
    chk("post_rst_r3", rdata[0], 32'h0);
    chk("post_rst_stall", stall, 1'b0);
    // write r5 with same-cycle bypass, then registered read
    drive();
    we = 2'b01; waddr[0] = 5'd5; wdata[0] = 32'h1234; raddr[1] = 5'd5;
    #1;
    chk("bypass_r5", rdata[1], 32'h1234);
    tick();
    drive();
    raddr[0] = 5'd5;
    #1;
    chk("read_r5", rdata[0], 32'h1234);
    // issue r7 then RAW stall resolved by writeback
    drive();
    issue = 1'b1; issue_we = 1'b1; issue_dest = 5'd7;
    #1;
    chk("issue7_stall", stall, 1'b0);
    tick();
    chk("pend7_set", pending, 32'h80);
    drive();
    raddr[0] = 5'd7;
    #1;
    chk("pend7_unused_nostall", stall, 1'b0);
    ruse = 2'b01;
    #1;
    chk("raw7_stall", stall, 1'b1);
    we = 2'b01; waddr[0] = 5'd7; wdata[0] = 32'hAA;
    #1;
    chk("raw7_wb_stall", stall, 1'b0);
    chk("raw7_wb_rdata", rdata[0], 32'hAA);
    tick();
    chk("pend7_clr", pending, 32'h0);
    // two ports write r3, highest wins
    drive();
    we = 2'b11; waddr[0] = 5'd3; wdata[0] = 32'h1; waddr[1] = 5'd3; wdata[1] = 32'h2; raddr[0] = 5'd3;
    #1;
    chk("dual_bypass_r3", rdata[0], 32'h2);
    tick();
    drive();
    raddr[0] = 5'd3;
    #1;
    chk("dual_store_r3", rdata[0], 32'h2);
    // register zero
    drive();
    we = 2'b01; waddr[0] = 5'd0; wdata[0] = 32'hFF; raddr[0] = 5'd0;
    #1;
    chk("r0_bypass_zero", rdata[0], 32'h0);
    tick();
    drive();
    raddr[0] = 5'd0; issue = 1'b1; issue_we = 1'b1; issue_dest = 5'd0;
    #1;
    chk("r0_read_zero", rdata[0], 32'h0);
    tick();
    chk("r0_never_pending", pending, 32'h0);
    // r9: WAW stall, ignored issue, and set-over-clear
    drive();
    issue = 1'b1; issue_we = 1'b1; issue_dest = 5'd9;
    tick();
    chk("pend9_set", pending, 32'h200);
    drive();
    issue = 1'b1; issue_we = 1'b1; issue_dest = 5'd9;
    #1;
    chk("waw9_stall", stall, 1'b1);
    issue_dest = 5'd10; ruse = 2'b10; raddr[1] = 5'd9;
    #1;
    chk("raw9_port1_stall", stall, 1'b1);
    tick();
    chk("stalled_issue_ignored", pending, 32'h200);
    drive();
    issue = 1'b1; issue_we = 1'b1; issue_dest = 5'd9;
    we = 2'b10; waddr[1] = 5'd9; wdata[1] = 32'h99;
    #1;
    chk("waw9_wb_stall", stall, 1'b0);
    tick();
    chk("set_wins_pend9", pending, 32'h200);
    drive();
    we = 2'b01; waddr[0] = 5'd9; wdata[0] = 32'h9A;
    tick();
    chk("pend9_clr", pending, 32'h0);
    // flush beats issue; writeback still stores
    drive();
    issue = 1'b1; issue_we = 1'b1; issue_dest = 5'd4;
    tick();
    drive();
    issue = 1'b1; issue_we = 1'b1; issue_dest = 5'd6;
    tick();
    chk("pend46_set", pending, 32'h50);
    drive();
    flush = 1'b1; issue = 1'b1; issue_we = 1'b1; issue_dest = 5'd8;
    we = 2'b01; waddr[0] = 5'd12; wdata[0] = 32'hC;
    tick();
    chk("flush_pending", pending, 32'h0);
    drive();
    raddr[0] = 5'd12;
    #1;
    chk("flush_wb_r12", rdata[0], 32'hC);
    // hold: nothing active keeps state
    tick();
    chk("hold_pending", pending, 32'h0);
    chk("hold_r12", rdata[0], 32'hC);
    // asynchronous reset mid-cycle
    drive();
    issue = 1'b1; issue_we = 1'b1; issue_dest = 5'd4;
    tick();
    drive();
    raddr[0] = 5'd5; raddr[1] = 5'd12; ruse = 2'b11;
    issue_dest = 5'd4; issue_we = 1'b1;
    #1;
    chk("pre_arst_pending", pending, 32'h10);
    chk("pre_arst_stall", stall, 1'b1);
    chk("pre_arst_r5", rdata[0], 32'h1234);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_pending", pending, 32'h0);
    chk("arst_stall", stall, 1'b0);
    chk("arst_r5", rdata[0], 32'h0);
    chk("arst_r12", rdata[1], 32'h0);
    drive();
    reset = 1'b1;
    raddr[0] = 5'd5; raddr[1] = 5'd12;
    #1;
    chk("post_arst_r5", rdata[0], 32'h0);
    chk("post_arst_r12", rdata[1], 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_regfile_scoreboard.md
DECODE_REGFILE_SCOREBOARD -- requirements
Module: decode_regfile_scoreboard

Interface
REQ-001 SHALL have parameter RPORTS, default 2, number of read ports.
REQ-002 SHALL have parameter WPORTS, default 1, number of write ports.
REQ-003 SHALL have parameter ADDR, default 5, register address width; register count = 2**ADDR.
REQ-004 SHALL have parameter WIDTH, default 32, data width.
REQ-005 SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads zero, ignores writes and is never marked pending.
REQ-006 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1; one clock, reset is asynchronous and active-low.
REQ-008 SHALL have port raddr, input, RPORTS x ADDR, read addresses.
REQ-009 SHALL have port ruse, input, RPORTS, read port actually consumed by the decoded instruction.
REQ-010 SHALL have port rdata, output, RPORTS x WIDTH, read data.
REQ-011 SHALL have port we, input, WPORTS, writeback enables.
REQ-012 SHALL have port waddr, input, WPORTS x ADDR, writeback addresses.
REQ-013 SHALL have port wdata, input, WPORTS x WIDTH, writeback data.
REQ-014 SHALL have port issue, input, 1, decoded instruction leaves decode this cycle.
REQ-015 SHALL have port issue_we, input, 1, issuing instruction writes a register.
REQ-016 SHALL have port issue_dest, input, ADDR, destination of issuing instruction.
REQ-017 SHALL have port flush, input, 1, synchronous discard of all in-flight writes.
REQ-018 SHALL have port stall, output, 1, decode must hold.
REQ-019 SHALL have port pending, output, 2**ADDR, scoreboard state, bit i = register i has an outstanding write.

Function
REQ-020 SHALL read combinationally: rdata[p] = regs[raddr[p]] unless bypassed.
REQ-021 SHALL bypass: if any we[w] and waddr[w]==raddr[p] this cycle, rdata[p] = wdata of the highest-index matching write port.
REQ-022 SHALL return zero on rdata[p] when ZERO_REG=1 and raddr[p]==0, regardless of bypass.
REQ-023 SHALL, when several write ports target one address in a cycle, store the data of the highest-index port.
REQ-024 SHALL clear pending[waddr[w]] at the edge when we[w]=1.
REQ-025 SHALL set pending[issue_dest] at the edge when issue=1, issue_we=1, stall=0, and not (ZERO_REG=1 and issue_dest==0).
REQ-026 SHALL let set win over clear when issue and writeback target the same register in one cycle (newest producer outstanding).
REQ-027 SHALL assert stall combinationally when, for any p, ruse[p]=1, pending[raddr[p]]=1, and no we[w] with waddr[w]==raddr[p] this cycle.
REQ-028 SHALL also assert stall when issue_we=1 and pending[issue_dest]=1 with no same-cycle writeback to it (WAW hold).
REQ-029 SHALL ignore issue when stall=1 (no scoreboard set).
REQ-030 SHALL, on flush=1, clear every pending bit at the edge; writebacks that cycle still update register contents; flush overrides a same-cycle issue set.
REQ-031 SHALL keep stall independent of issue (no combinational loop issue->stall).
REQ-032 SHALL hold register and pending state when no we, issue or flush is active.

Reset
REQ-033 SHALL, while reset=0, asynchronously clear all registers to 0 and all pending bits to 0.
REQ-034 SHALL drive stall=0, pending=0 and rdata=0 for every port during and immediately after reset.
REQ-035 SHALL discard any writeback or issue coincident with the cycle reset deasserts only if reset is still low at that edge.

Verification
REQ-036 SHALL cover: write r5=0x1234 port0, next cycle raddr0=5 -> rdata0=0x1234; same-cycle raddr1=5 with we -> rdata1=0x1234 via bypass.
REQ-037 SHALL cover: issue dest r7, next cycle ruse0=1 raddr0=7 -> stall=1; we r7=0xAA -> stall=0 that cycle, rdata0=0xAA, pending[7]=0 after edge.
REQ-038 SHALL cover: WPORTS=2, both write r3 (0x1, 0x2) -> r3=0x2; write r0=0xFF -> r0 reads 0, issue dest 0 -> pending[0]=0.
REQ-039 SHALL cover: pending[9]=1, issue dest 9 with writeback to 9 same cycle -> stall=0, pending[9]=1 after edge.
REQ-040 SHALL cover: pending r4,r6 set, flush=1 with issue dest 8 -> pending all 0 next cycle.
REQ-041 SHALL cover: pending and registers non-zero, reset pulsed low mid-cycle -> pending=0, all reads 0 immediately without a clock edge.
